// File: rtl/ram_1w2r_fwd.sv
// ============================================================================
//  Module   : ram_1w2r_fwd
//  Purpose  : Three-way read-data select for one read port of ram_1w2r.
//             Picks the newest copy of the addressed word: the live write
//             port first, then the staged write, then the stored array word.
//  Ports    : wr_en_i / wr_addr_i / wr_data_i    live write port
//             ws_valid_i / ws_addr_i / ws_data_i staged (not yet committed) write
//             rd_addr_i                          read address of this port
//             mem_data_i                         array word at rd_addr_i
//             rd_data_o                          next read word (combinational)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_1w2r_fwd #(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 8
) (
  input  logic              wr_en_i,
  input  logic [DEEPTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              ws_valid_i,
  input  logic [DEEPTH-1:0] ws_addr_i,
  input  logic [WIDTH-1:0]  ws_data_i,
  input  logic [DEEPTH-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  mem_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic hit_live;
  logic hit_stage;

  // Full-width address equality; no partial-address aliasing.
  assign hit_live  = wr_en_i    && (wr_addr_i == rd_addr_i);
  assign hit_stage = ws_valid_i && (ws_addr_i == rd_addr_i);

  // The live write is younger than the staged one, so it wins when both
  // target the same address (back-to-back writes to one location).
  always_comb begin
    rd_data_o = mem_data_i;
    if (hit_live) begin
      rd_data_o = wr_data_i;
    end else if (hit_stage) begin
      rd_data_o = ws_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_1w2r.sv
// ============================================================================
//  Module   : ram_1w2r
//  Purpose  : Single-write, dual-read synchronous RAM. Writes pass through a
//             one-entry stage before committing to the array; both read
//             ports forward from the live write and the stage so every read
//             observes the newest data for its address. Read data is
//             registered (1-cycle latency) and held while the enable is low.
//  Ports    : clk, rst                       clock, synchronous active-high reset
//             write_addr/write_data/write_EN write port
//             read_addr_A/read_EN_A          read port A request
//             read_addr_B/read_EN_B          read port B request
//             read_data_A/read_data_B        registered read data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_1w2r #(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEEPTH-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              write_EN,
  input  logic [DEEPTH-1:0] read_addr_A,
  input  logic              read_EN_A,
  input  logic [DEEPTH-1:0] read_addr_B,
  input  logic              read_EN_B,
  output logic [WIDTH-1:0]  read_data_A,
  output logic [WIDTH-1:0]  read_data_B
);

  localparam int LINES = 1 << DEEPTH;

  // Storage: no reset so it maps onto distributed or block RAM.
  logic [WIDTH-1:0] mem_q [0:LINES-1];

  // Write stage.
  logic              ws_valid_q;
  logic [DEEPTH-1:0] ws_addr_q;
  logic [WIDTH-1:0]  ws_data_q;

  // Read output registers and their next values.
  logic [WIDTH-1:0]  rd_a_q, rd_a_d;
  logic [WIDTH-1:0]  rd_b_q, rd_b_d;
  logic [WIDTH-1:0]  mem_a;
  logic [WIDTH-1:0]  mem_b;
  logic [WIDTH-1:0]  fwd_a;
  logic [WIDTH-1:0]  fwd_b;

  assign mem_a = mem_q[read_addr_A];
  assign mem_b = mem_q[read_addr_B];

  ram_1w2r_fwd #(
    .WIDTH  (WIDTH),
    .DEEPTH (DEEPTH)
  ) u_fwd_a (
    .wr_en_i    (write_EN),
    .wr_addr_i  (write_addr),
    .wr_data_i  (write_data),
    .ws_valid_i (ws_valid_q),
    .ws_addr_i  (ws_addr_q),
    .ws_data_i  (ws_data_q),
    .rd_addr_i  (read_addr_A),
    .mem_data_i (mem_a),
    .rd_data_o  (fwd_a)
  );

  ram_1w2r_fwd #(
    .WIDTH  (WIDTH),
    .DEEPTH (DEEPTH)
  ) u_fwd_b (
    .wr_en_i    (write_EN),
    .wr_addr_i  (write_addr),
    .wr_data_i  (write_data),
    .ws_valid_i (ws_valid_q),
    .ws_addr_i  (ws_addr_q),
    .ws_data_i  (ws_data_q),
    .rd_addr_i  (read_addr_B),
    .mem_data_i (mem_b),
    .rd_data_o  (fwd_b)
  );

  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (read_EN_A) begin
      rd_a_d = fwd_a;
    end
    if (read_EN_B) begin
      rd_b_d = fwd_b;
    end
  end

  // Commit the staged write. Gated by rst so a write caught in the stage at
  // the reset edge is dropped rather than committed.
  always_ff @(posedge clk) begin
    if (!rst && ws_valid_q) begin
      mem_q[ws_addr_q] <= ws_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid_q <= 1'b0;
      ws_addr_q  <= '0;
      ws_data_q  <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
    end else begin
      ws_valid_q <= write_EN;
      if (write_EN) begin
        ws_addr_q <= write_addr;
        ws_data_q <= write_data;
      end
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign read_data_A = rd_a_q;
  assign read_data_B = rd_b_q;

endmodule

`default_nettype wire
